// File: rtl/pipeline_stall_u.sv
// Pipeline hazard/stall controller: memory-wait interlock, load-use bubble, wait and stall counters.
// Optional memory-timeout fault state is built when STALL_TIMEOUT_EN is defined.
module pipeline_stall_u #(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CNT_W          = 8,
  parameter int PERF_W         = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              imem_ack_n,
  input  logic              dmem_ack_n,
  input  logic [6:0]        mem_opcode,
  input  logic [6:0]        ex_opcode,
  input  logic [4:0]        ex_rd,
  input  logic [4:0]        id_rs1,
  input  logic [4:0]        id_rs2,
  input  logic              id_uses_rs1,
  input  logic              id_uses_rs2,
  output logic              interlock,
  output logic              stall_front,
  output logic              bubble_ex,
  output logic              timeout_err,
  output logic [CNT_W-1:0]  wait_cnt,
  output logic [PERF_W-1:0] stall_cnt
);

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;

  localparam logic [1:0] ST_RUN   = 2'd0;
  localparam logic [1:0] ST_WAIT  = 2'd1;
  localparam logic [1:0] ST_FAULT = 2'd2;

  localparam logic [CNT_W-1:0]  WAIT_MAX  = '1;
  localparam logic [PERF_W-1:0] STALL_MAX = '1;

  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > (2**CNT_W) - 1) begin : g_bad_timeout
    $error("pipeline_stall_u: TIMEOUT_CYCLES out of range for CNT_W");
  end

  logic [1:0]        state_reg, state_next;
  logic [CNT_W-1:0]  wait_cnt_reg, wait_cnt_next;
  logic [PERF_W-1:0] stall_cnt_reg, stall_cnt_next;

  logic mem_access;
  logic mem_wait;
  logic load_use;
  logic in_fault;
  logic hold_req;
  logic bubble_req;
  logic stall_req;
  logic timeout_hit;

  assign mem_access = (mem_opcode == OP_LOAD) | (mem_opcode == OP_STORE);
  assign mem_wait   = imem_ack_n | (dmem_ack_n & mem_access);
  assign load_use   = (ex_opcode == OP_LOAD) & (ex_rd != 5'd0) &
                      ((id_uses_rs1 & (id_rs1 == ex_rd)) | (id_uses_rs2 & (id_rs2 == ex_rd)));

  assign in_fault   = (state_reg == ST_FAULT);
  assign hold_req   = mem_wait | in_fault;
  // A full freeze already holds the load in EX, so no bubble is needed then.
  assign bubble_req = load_use & ~hold_req;
  assign stall_req  = hold_req | bubble_req;

  // Reset forces the pipeline frozen without injecting bubbles.
  assign interlock   = ~rst_n | hold_req;
  assign stall_front = ~rst_n | stall_req;
  assign bubble_ex   = rst_n & bubble_req;

`ifdef STALL_TIMEOUT_EN
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  logic timeout_err_reg;

  assign timeout_hit = mem_wait & (wait_cnt_reg == TIMEOUT_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timeout_err_reg <= 1'b0;
    end else if (timeout_hit) begin
      timeout_err_reg <= 1'b1;
    end
  end

  assign timeout_err = timeout_err_reg;
`else
  assign timeout_hit = 1'b0;
  assign timeout_err = 1'b0;
`endif

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_RUN: begin
        if (timeout_hit) begin
          state_next = ST_FAULT;
        end else if (mem_wait) begin
          state_next = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (timeout_hit) begin
          state_next = ST_FAULT;
        end else if (!mem_wait) begin
          state_next = ST_RUN;
        end
      end
      ST_FAULT: state_next = ST_FAULT;
      default:  state_next = ST_RUN;
    endcase
  end

  always_comb begin
    wait_cnt_next = wait_cnt_reg;
    if (in_fault) begin
      wait_cnt_next = wait_cnt_reg;
    end else if (mem_wait) begin
      if (wait_cnt_reg != WAIT_MAX) begin
        wait_cnt_next = wait_cnt_reg + 1'b1;
      end
    end else begin
      wait_cnt_next = '0;
    end
  end

  always_comb begin
    stall_cnt_next = stall_cnt_reg;
    if (stall_req && (stall_cnt_reg != STALL_MAX)) begin
      stall_cnt_next = stall_cnt_reg + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= ST_RUN;
      wait_cnt_reg  <= '0;
      stall_cnt_reg <= '0;
    end else begin
      state_reg     <= state_next;
      wait_cnt_reg  <= wait_cnt_next;
      stall_cnt_reg <= stall_cnt_next;
    end
  end

  assign wait_cnt  = wait_cnt_reg;
  assign stall_cnt = stall_cnt_reg;

endmodule

// File: tb/tb_pipeline_stall_u.sv
// Directed self-checking bench for pipeline_stall_u (TIMEOUT_CYCLES=4, PERF_W=4).
// Expectations follow STALL_TIMEOUT_EN so the bench suits either build.
module tb_pipeline_stall_u;

`ifdef STALL_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_ALU   = 7'b0110011;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       imem_ack_n, dmem_ack_n;
  logic [6:0] mem_opcode, ex_opcode;
  logic [4:0] ex_rd, id_rs1, id_rs2;
  logic       id_uses_rs1, id_uses_rs2;
  logic       interlock, stall_front, bubble_ex, timeout_err;
  logic [7:0] wait_cnt;
  logic [3:0] stall_cnt;

  int n_cmp = 0;
  int n_mis = 0;

  pipeline_stall_u #(
    .TIMEOUT_CYCLES(4),
    .CNT_W(8),
    .PERF_W(4)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .imem_ack_n(imem_ack_n),
    .dmem_ack_n(dmem_ack_n),
    .mem_opcode(mem_opcode),
    .ex_opcode(ex_opcode),
    .ex_rd(ex_rd),
    .id_rs1(id_rs1),
    .id_rs2(id_rs2),
    .id_uses_rs1(id_uses_rs1),
    .id_uses_rs2(id_uses_rs2),
    .interlock(interlock),
    .stall_front(stall_front),
    .bubble_ex(bubble_ex),
    .timeout_err(timeout_err),
    .wait_cnt(wait_cnt),
    .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    imem_ack_n = 1'b0; dmem_ack_n = 1'b0;
    mem_opcode = OP_ALU; ex_opcode = OP_LOAD;
    ex_rd = 5'd5; id_rs1 = 5'd0; id_rs2 = 5'd5;
    id_uses_rs1 = 1'b0; id_uses_rs2 = 1'b1;
    #1;
    // Reset outputs, with a load-use hazard present that must not bubble
    check("rst_interlock",   interlock,   1);
    check("rst_stall_front", stall_front, 1);
    check("rst_bubble_ex",   bubble_ex,   0);
    check("rst_wait_cnt",    wait_cnt,    0);
    check("rst_stall_cnt",   stall_cnt,   0);
    check("rst_timeout_err", timeout_err, 0);
    ex_opcode = OP_ALU; ex_rd = 5'd0; id_rs2 = 5'd0; id_uses_rs2 = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    check("run_interlock",   interlock,   0);
    check("run_stall_front", stall_front, 0);
    check("run_stall_cnt",   stall_cnt,   0);

    // Load in MEM: every ack combination
    mem_opcode = OP_LOAD;
    imem_ack_n = 1'b0; dmem_ack_n = 1'b0; #1; check("ld_acks00", interlock, 0);
    imem_ack_n = 1'b0; dmem_ack_n = 1'b1; #1; check("ld_acks01", interlock, 1);
    imem_ack_n = 1'b1; dmem_ack_n = 1'b0; #1; check("ld_acks10", interlock, 1);
    imem_ack_n = 1'b1; dmem_ack_n = 1'b1; #1; check("ld_acks11", interlock, 1);
    imem_ack_n = 1'b0; dmem_ack_n = 1'b0; mem_opcode = OP_ALU;
    tick();

    // ALU in MEM ignores dmem ack; store honours it
    dmem_ack_n = 1'b1; #1; check("alu_acks01", interlock, 0);
    imem_ack_n = 1'b1; dmem_ack_n = 1'b0; #1; check("alu_acks10", interlock, 1);
    imem_ack_n = 1'b0; dmem_ack_n = 1'b1; mem_opcode = OP_STORE; #1;
    check("st_acks01", interlock, 1);
    dmem_ack_n = 1'b0; mem_opcode = OP_ALU;
    tick();
    check("quiet_stall_cnt", stall_cnt, 0);
    check("quiet_wait_cnt",  wait_cnt,  0);

    // Load-use through rs2
    ex_opcode = OP_LOAD; ex_rd = 5'd5; id_rs2 = 5'd5; id_uses_rs2 = 1'b1; #1;
    check("lu_bubble_ex",   bubble_ex,   1);
    check("lu_stall_front", stall_front, 1);
    check("lu_interlock",   interlock,   0);
    tick();
    check("lu_stall_cnt", stall_cnt, 1);
    ex_rd = 5'd0; #1;
    check("x0_bubble_ex",   bubble_ex,   0);
    check("x0_stall_front", stall_front, 0);
    tick();
    check("x0_stall_cnt", stall_cnt, 1);

    // Load-use through rs1, and with the read flag cleared
    ex_rd = 5'd7; id_rs1 = 5'd7; id_uses_rs1 = 1'b1; id_uses_rs2 = 1'b0; #1;
    check("rs1_bubble_ex", bubble_ex, 1);
    id_uses_rs1 = 1'b0; #1;
    check("rs1_unused_bubble_ex", bubble_ex, 0);
    tick();
    check("rs1_stall_cnt", stall_cnt, 1);

    // Load-use coinciding with a memory wait: interlock wins
    ex_rd = 5'd5; id_rs2 = 5'd5; id_uses_rs2 = 1'b1; imem_ack_n = 1'b1; #1;
    check("prio_interlock",   interlock,   1);
    check("prio_bubble_ex",   bubble_ex,   0);
    check("prio_stall_front", stall_front, 1);
    tick();
    check("prio_wait_cnt",  wait_cnt,  1);
    check("prio_stall_cnt", stall_cnt, 2);
    imem_ack_n = 1'b0; ex_opcode = OP_ALU; #1;
    check("ack_back_interlock", interlock, 0);
    tick();
    check("ack_back_wait_cnt",  wait_cnt,  0);
    check("ack_back_stall_cnt", stall_cnt, 2);

    // Timeout after 4 wait cycles
    imem_ack_n = 1'b1;
    tick(); tick(); tick();
    check("to3_wait_cnt",    wait_cnt,    3);
    check("to3_timeout_err", timeout_err, 0);
    tick();
    check("to4_wait_cnt",    wait_cnt,    4);
    check("to4_timeout_err", timeout_err, TO_EN ? 1 : 0);
    check("to4_stall_cnt",   stall_cnt,   6);
    imem_ack_n = 1'b0; #1;
    check("fault_interlock", interlock, TO_EN ? 1 : 0);
    tick();
    check("fault_wait_cnt",    wait_cnt,    TO_EN ? 4 : 0);
    check("fault_stall_cnt",   stall_cnt,   TO_EN ? 7 : 6);
    check("fault_interlock2",  interlock,   TO_EN ? 1 : 0);
    check("fault_timeout_err", timeout_err, TO_EN ? 1 : 0);
    rst_n = 1'b0; #1;
    check("frst_timeout_err", timeout_err, 0);
    check("frst_wait_cnt",    wait_cnt,    0);
    check("frst_stall_cnt",   stall_cnt,   0);
    check("frst_interlock",   interlock,   1);
    tick();
    rst_n = 1'b1;
    tick();
    check("frel_interlock", interlock, 0);
    check("frel_stall_cnt", stall_cnt, 0);

    // Asynchronous reset mid-WAIT
    imem_ack_n = 1'b1;
    tick(); tick();
    check("mw_wait_cnt",  wait_cnt,  2);
    check("mw_stall_cnt", stall_cnt, 2);
    rst_n = 1'b0; #1;
    check("mwrst_wait_cnt",    wait_cnt,    0);
    check("mwrst_stall_cnt",   stall_cnt,   0);
    check("mwrst_timeout_err", timeout_err, 0);
    check("mwrst_interlock",   interlock,   1);
    imem_ack_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    check("mwrel_interlock", interlock, 0);
    check("mwrel_wait_cnt",  wait_cnt,  0);

    // Counter saturation
    imem_ack_n = 1'b1;
    for (int i = 0; i < 20; i++) tick();
    check("sat_stall_cnt", stall_cnt, 15);
    check("sat20_wait_cnt", wait_cnt, TO_EN ? 4 : 20);
    for (int i = 0; i < 300; i++) tick();
    check("sat_wait_cnt",   wait_cnt,  TO_EN ? 4 : 255);
    check("sat_stall_hold", stall_cnt, 15);
    imem_ack_n = 1'b0;
    tick();
    check("end_wait_cnt",  wait_cnt,  TO_EN ? 4 : 0);
    check("end_interlock", interlock, TO_EN ? 1 : 0);
    check("end_stall_cnt", stall_cnt, 15);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
